// File: rtl/acond_sensores.sv
// Input conditioning ahead of the alarm state machine: two-flop synchronizers,
// per-channel debounce, and a 4-sample current average with a hysteretic over-current flag.
module acond_sensores #(
    parameter int DEB_CYCLES  = 16,
    parameter int UMBRAL_ALTO = 20,
    parameter int UMBRAL_BAJO = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interruptor_raw,
    input  logic       temp_raw,
    input  logic       humo_raw,
    input  logic [4:0] corriente_raw,
    input  logic       corriente_valid,
    output logic       interruptor,
    output logic       temp,
    output logic       humo,
    output logic [4:0] corriente,
    output logic       corriente_listo,
    output logic       sobrecorriente
);

    localparam logic [15:0] DEB_MAX = 16'(DEB_CYCLES - 1);
    localparam logic [4:0]  ALTO    = 5'(UMBRAL_ALTO);
    localparam logic [4:0]  BAJO    = 5'(UMBRAL_BAJO);

    // Bit 0 = interruptor, bit 1 = temp, bit 2 = humo.
    logic [2:0]  raw_bus;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  deb;
    logic [15:0] cnt [3];

    assign raw_bus = {humo_raw, temp_raw, interruptor_raw};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw_bus;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign interruptor = deb[0];
    assign temp        = deb[1];
    assign humo        = deb[2];

    // corriente_valid is a one-cycle strobe with no back-pressure: every
    // strobed sample is accepted, and yields exactly one corriente_listo pulse
    // on the following edge.
    logic [4:0] win [4];
    logic [6:0] sum;
    logic       valid_d;
    logic [4:0] avg;

    assign avg = sum[6:2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) win[i] <= '0;
            sum     <= '0;
            valid_d <= 1'b0;
        end else begin
            valid_d <= corriente_valid;
            if (corriente_valid) begin
                win[0] <= corriente_raw;
                for (int i = 1; i < 4; i++) win[i] <= win[i-1];
                // Max 4*31 = 124 fits in 7 bits, so no overflow.
                sum <= sum + 7'(corriente_raw) - 7'(win[3]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            corriente       <= '0;
            corriente_listo <= 1'b0;
            sobrecorriente  <= 1'b0;
        end else begin
            corriente_listo <= valid_d;
            if (valid_d) begin
                corriente <= avg;
                if (avg >= ALTO)
                    sobrecorriente <= 1'b1;
                else if (avg <= BAJO)
                    sobrecorriente <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acond_sensores.sv
// Directed bench for acond_sensores with DEB_CYCLES=4: reset, debounce edges,
// bounce rejection, averaging, hysteresis, back-to-back strobes and mid-run reset.
module tb_acond_sensores;

    logic       clk;
    logic       rst;
    logic       interruptor_raw;
    logic       temp_raw;
    logic       humo_raw;
    logic [4:0] corriente_raw;
    logic       corriente_valid;
    logic       interruptor;
    logic       temp;
    logic       humo;
    logic [4:0] corriente;
    logic       corriente_listo;
    logic       sobrecorriente;

    int checks = 0;
    int errors = 0;

    acond_sensores #(
        .DEB_CYCLES (4),
        .UMBRAL_ALTO(20),
        .UMBRAL_BAJO(12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interruptor_raw(interruptor_raw),
        .temp_raw       (temp_raw),
        .humo_raw       (humo_raw),
        .corriente_raw  (corriente_raw),
        .corriente_valid(corriente_valid),
        .interruptor    (interruptor),
        .temp           (temp),
        .humo           (humo),
        .corriente      (corriente),
        .corriente_listo(corriente_listo),
        .sobrecorriente (sobrecorriente)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        interruptor_raw = 1'b1; temp_raw = 1'b1; humo_raw = 1'b1;
        corriente_raw = 5'd31; corriente_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if ({interruptor, temp, humo, corriente, corriente_listo, sobrecorriente} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {interruptor, temp, humo, corriente, corriente_listo, sobrecorriente});
        end
        rst = 1'b1;
        corriente_valid = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if ({interruptor, temp, humo} !== ((t >= 6) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL reset_release_edge%0d: got %b required %b", t,
                         {interruptor, temp, humo}, (t >= 6) ? 3'b111 : 3'b000);
            end
            checks++;
            if (corriente !== 5'd0 || corriente_listo !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_corriente%0d: got %0d/%b required 0/0", t,
                         corriente, corriente_listo);
            end
        end
        interruptor_raw = 1'b0; temp_raw = 1'b0; humo_raw = 1'b0;
        repeat (8) tick();
        checks++;
        if ({interruptor, temp, humo} !== 3'b000) begin
            errors++;
            $display("FAIL reset_cleanup: got %b required 000", {interruptor, temp, humo});
        end
    endtask

    task automatic test_clean_edge();
        humo_raw = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if (humo !== (t >= 6)) begin
                errors++;
                $display("FAIL humo_rise_edge%0d: got %b required %b", t, humo, t >= 6);
            end
        end
        humo_raw = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if (humo !== (t < 6)) begin
                errors++;
                $display("FAIL humo_fall_edge%0d: got %b required %b", t, humo, t < 6);
            end
        end
    endtask

    task automatic test_bounce();
        // Raw 1 sampled at edges 1-3, 0 at 4-6, 1 from edge 7: output at edge 12.
        for (int t = 1; t <= 14; t++) begin
            temp_raw = (t <= 3 || t >= 7);
            tick();
            checks++;
            if (temp !== (t >= 12)) begin
                errors++;
                $display("FAIL temp_bounce_edge%0d: got %b required %b", t, temp, t >= 12);
            end
        end
        temp_raw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic strobe(input logic [4:0] v, input logic [4:0] exp_avg,
                          input logic exp_sobre, input string name);
        corriente_raw = v;
        corriente_valid = 1'b1;
        tick();
        corriente_valid = 1'b0;
        corriente_raw = 5'd0;
        checks++;
        if (corriente_listo !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_listo: got %b required 0", name, corriente_listo);
        end
        tick();
        checks++;
        if (corriente !== exp_avg || corriente_listo !== 1'b1 || sobrecorriente !== exp_sobre) begin
            errors++;
            $display("FAIL %s: got avg=%0d listo=%b sobre=%b required avg=%0d listo=1 sobre=%b",
                     name, corriente, corriente_listo, sobrecorriente, exp_avg, exp_sobre);
        end
    endtask

    task automatic test_average_set();
        strobe(5'd21, 5'd5,  1'b0, "avg_set1");
        strobe(5'd21, 5'd10, 1'b0, "avg_set2");
        strobe(5'd21, 5'd15, 1'b0, "avg_set3");
        strobe(5'd21, 5'd21, 1'b1, "avg_set4");
    endtask

    task automatic test_hysteresis_clear();
        strobe(5'd5, 5'd17, 1'b1, "hyst1");
        strobe(5'd5, 5'd13, 1'b1, "hyst2");
        strobe(5'd5, 5'd9,  1'b0, "hyst3");
        strobe(5'd5, 5'd5,  1'b0, "hyst4");
    endtask

    task automatic test_back_to_back();
        logic [4:0] vals [4];
        logic [4:0] exps [4];
        vals = '{5'd4, 5'd8, 5'd12, 5'd16};
        exps = '{5'd4, 5'd5, 5'd7, 5'd10};
        corriente_valid = 1'b1;
        corriente_raw = vals[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) corriente_raw = vals[i+1];
            else corriente_valid = 1'b0;
            tick();
            checks++;
            if (corriente !== exps[i] || corriente_listo !== 1'b1 || sobrecorriente !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: got avg=%0d listo=%b sobre=%b required avg=%0d listo=1 sobre=0",
                         i, corriente, corriente_listo, sobrecorriente, exps[i]);
            end
        end
        tick();
        checks++;
        if (corriente_listo !== 1'b0) begin
            errors++;
            $display("FAIL b2b_listo_drop: got %b required 0", corriente_listo);
        end
    endtask

    task automatic test_ignore_invalid();
        corriente_raw = 5'd31;
        corriente_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (corriente !== 5'd10 || corriente_listo !== 1'b0) begin
            errors++;
            $display("FAIL ignore_invalid: got avg=%0d listo=%b required avg=10 listo=0",
                     corriente, corriente_listo);
        end
        // Window 16,12,8,4 -> shifting in 0 drops 4: sum 36, avg 9.
        strobe(5'd0, 5'd9, 1'b0, "after_invalid");
    endtask

    task automatic test_reset_mid();
        strobe(5'd31, 5'd14, 1'b0, "pre_rst1");
        strobe(5'd31, 5'd19, 1'b0, "pre_rst2");
        interruptor_raw = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        interruptor_raw = 1'b0;
        tick();
        checks++;
        if ({interruptor, temp, humo, corriente, corriente_listo, sobrecorriente} !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 0",
                     {interruptor, temp, humo, corriente, corriente_listo, sobrecorriente});
        end
        rst = 1'b1;
        strobe(5'd8, 5'd2, 1'b0, "post_rst");
        repeat (6) tick();
        checks++;
        if (interruptor !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_interruptor: got %b required 0", interruptor);
        end
    endtask

    initial begin
        rst = 1'b0;
        interruptor_raw = 1'b0; temp_raw = 1'b0; humo_raw = 1'b0;
        corriente_raw = 5'd0; corriente_valid = 1'b0;
        #2;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_average_set();
        test_hysteresis_clear();
        test_back_to_back();
        test_ignore_invalid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acond_sensores.md
Name: acond_sensores

Overview:
- Input-conditioning stage directly upstream of the alarm state machine (`maquinaestados`).
- Takes the raw asynchronous switch and sensor lines (interruptor, temp, humo) and the raw 5-bit current samples from the board.
- Produces synchronized, debounced levels and a 4-sample averaged current with over-current hysteresis flag.
- All outputs are registered and drive the state machine's inputs directly.

Parameters:
- DEB_CYCLES, 16: consecutive stable cycles required before a debounced output changes. Legal range 2..65535.
- UMBRAL_ALTO, 20: average-current level at or above which sobrecorriente sets.
- UMBRAL_BAJO, 12: average-current level at or below which sobrecorriente clears. UMBRAL_BAJO < UMBRAL_ALTO required.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- interruptor_raw  in  1  raw switch, asynchronous.
- temp_raw  in  1  raw temperature-comparator line, asynchronous.
- humo_raw  in  1  raw smoke-detector line, asynchronous.
- corriente_raw  in  5  current sample, unsigned; synchronous to clk.
- corriente_valid  in  1  one-cycle strobe; corriente_raw is valid this cycle.
- interruptor  out  1  debounced switch level.
- temp  out  1  debounced temperature level.
- humo  out  1  debounced smoke level.
- corriente  out  5  moving average of last 4 samples.
- corriente_listo  out  1  one-cycle pulse; corriente/sobrecorriente updated.
- sobrecorriente  out  1  hysteretic over-current flag.

Behaviour:
- Reset (rst=0 at rising edge):
  - All outputs are 0.
  - Synchronizer flops, debounce counters, 4-entry sample window and running sum are cleared.
  - Reset overrides every other event in that cycle, including corriente_valid.
  - Reset asserted mid-debounce or mid-window discards all partial state.
- Synchronizer: each raw digital line passes through 2 flops, giving s_x.
- Debounce, independent per channel, counter cnt_x of 16 bits:
  - If s_x == out_x: cnt_x <= 0.
  - Else if cnt_x == DEB_CYCLES-1: out_x <= s_x and cnt_x <= 0.
  - Else: cnt_x <= cnt_x+1.
  - A raw change held steady appears on the output exactly DEB_CYCLES+2 rising edges after the first edge that samples it.
  - Any glitch shorter than DEB_CYCLES cycles (as seen at s_x) produces no output change and restarts the count.
  - The counter never wraps.
- Current window:
  - On an edge with corriente_valid=1, shift corriente_raw into a 4-deep window.
  - Update in the same edge: sum <= sum + corriente_raw - oldest. sum is 7 bits; max 124, so it never overflows.
  - Window entries start at 0, so the first three averages include zeros.
- Output stage, one edge after the sum update:
  - corriente <= sum[6:2] (truncating divide by 4).
  - corriente_listo <= 1 for exactly one cycle.
  - Hysteresis, evaluated on the new average in the same edge:
    - If avg >= UMBRAL_ALTO: sobrecorriente <= 1.
    - Else if avg <= UMBRAL_BAJO: sobrecorriente <= 0.
    - Else: hold.
  - Total latency: valid sampled at edge N; corriente, corriente_listo and sobrecorriente change at edge N+1.
- Back-to-back strobes (valid high every cycle) are accepted at full rate. Each produces its own corriente_listo pulse, so corriente_listo stays high continuously.
- corriente_raw is ignored when corriente_valid=0.
- The digital channels and the current path operate independently; simultaneous events do not interact.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all raw inputs=1 and valid=1 → all outputs 0; after release, no output changes before DEB_CYCLES+2 edges.
- Clean edge (DEB_CYCLES=4 in bench): humo_raw 0→1 held → humo=1 exactly 6 edges later; 1→0 likewise 6 edges later.
- Bounce: temp_raw toggles 1,0,1 with 3-cycle pulses, then holds 1 → temp stays 0 through the bounces and rises 6 edges after the final rising edge.
- Average and set: four strobes of 21 → corriente 5, 10, 15, 21 with one corriente_listo per strobe; sobrecorriente=1 only after the 4th (21 >= 20).
- Hysteresis clear: then four strobes of 5 → corriente 17, 13, 9, 5; sobrecorriente stays 1 at 17 and 13, clears at 9.
- Reset mid-operation: after two strobes of 31 and mid-debounce of interruptor_raw, pulse rst=0 → all outputs 0; next strobe of 8 → corriente=2 (window restarted from zeros).
